// File: rtl/shake_pkg.sv
// Shared SHAKE256 datapath constants and the launch payload carried to the pipeline.
package shake_pkg;

    localparam int unsigned DATA_W = 1088;
    localparam int unsigned LEN_W  = 11;
    localparam int unsigned HASH_W = 256;

    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [DATA_W-1:0] data;
    } launch_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-bit wrap pointers; head is visible combinationally on dout.
module sync_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [AW:0]  count
);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    // Pointer difference is exact because both pointers carry one wrap bit.
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && (count != (AW+1)'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/shake256_sched.sv
// Credit-limited round-robin scheduler feeding an in-order SHAKE256 pipeline and
// returning tagged digests through an output buffer.
module shake256_sched
    import shake_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2,
    parameter int unsigned CRED = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*LEN_W-1:0]  req_len,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic                   pipe_en,
    output logic [LEN_W-1:0]       pipe_len,
    output logic [DATA_W-1:0]      pipe_data,
    input  logic                   pipe_done,
    input  logic [HASH_W-1:0]      pipe_hash,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [HASH_W-1:0]      rsp_hash,
    output logic                   err
);

    localparam int unsigned CW = $clog2(CRED) + 1;
    localparam int unsigned OW = IDW + HASH_W;

    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    gnt_idx;
    logic              gnt_any;
    logic              xfer;
    logic [CW-1:0]     credit;
    logic [CW-1:0]     id_count;
    logic [CW-1:0]     out_count;
    logic [IDW-1:0]    id_head;
    logic [OW-1:0]     out_head;
    logic              id_empty;
    logic              done_ok;
    launch_t           launch_q;
    logic [LEN_W-1:0]  len_arr  [NREQ];
    logic [DATA_W-1:0] data_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign len_arr[g]  = req_len[g*LEN_W +: LEN_W];
        assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    end

    // Every issued job holds one credit until its response leaves the output buffer.
    assign credit   = CW'(CRED) - id_count - out_count;
    assign id_empty = (id_count == '0);
    assign done_ok  = pipe_done && !id_empty;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (!gnt_any && req_valid[IDW'((32'(rr_ptr) + k) % NREQ)]) begin
                gnt_any = 1'b1;
                gnt_idx = IDW'((32'(rr_ptr) + k) % NREQ);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (gnt_any && (credit != '0) && !rst) req_ready[gnt_idx] = 1'b1;
    end

    assign xfer = |req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_en  <= 1'b0;
            launch_q <= '0;
            rr_ptr   <= IDW'(NREQ - 1);
            err      <= 1'b0;
        end else begin
            pipe_en <= xfer;
            if (xfer) begin
                launch_q.len  <= len_arr[gnt_idx];
                launch_q.data <= data_arr[gnt_idx];
                rr_ptr        <= gnt_idx;
            end
            if (pipe_done && id_empty) err <= 1'b1;
        end
    end

    assign pipe_len  = launch_q.len;
    assign pipe_data = launch_q.data;

    sync_fifo #(.W(IDW), .DEPTH(CRED)) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (xfer),
        .din   (gnt_idx),
        .pop   (done_ok),
        .dout  (id_head),
        .count (id_count)
    );

    sync_fifo #(.W(OW), .DEPTH(CRED)) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (done_ok),
        .din   ({id_head, pipe_hash}),
        .pop   (rsp_valid && rsp_ready),
        .dout  (out_head),
        .count (out_count)
    );

    // Stale buffer contents are masked so an empty buffer presents zeros.
    assign rsp_valid = (out_count != '0);
    assign rsp_id    = rsp_valid ? out_head[OW-1 -: IDW] : '0;
    assign rsp_hash  = rsp_valid ? out_head[HASH_W-1:0] : '0;

endmodule

// File: tb/tb_shake256_sched.sv
// Scoreboard bench: transfers push expected launches and responses; a negedge monitor
// compares the DUT against a transaction-level model of credits, arbitration and ordering.
module tb_shake256_sched;
    import shake_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;
    localparam int unsigned CRED = 16;
    localparam int unsigned RW   = IDW + HASH_W;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*LEN_W-1:0]  req_len;
    logic [NREQ*DATA_W-1:0] req_data;
    logic                   pipe_en;
    logic [LEN_W-1:0]       pipe_len;
    logic [DATA_W-1:0]      pipe_data;
    logic                   pipe_done;
    logic [HASH_W-1:0]      pipe_hash;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic [HASH_W-1:0]      rsp_hash;
    logic                   err;

    shake256_sched #(.NREQ(NREQ), .IDW(IDW), .CRED(CRED)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_len(req_len), .req_data(req_data), .pipe_en(pipe_en), .pipe_len(pipe_len),
        .pipe_data(pipe_data), .pipe_done(pipe_done), .pipe_hash(pipe_hash),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_hash(rsp_hash), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                id;
        logic [LEN_W-1:0]  len;
        logic [DATA_W-1:0] data;
    } job_t;

    int n_tests = 0;
    int n_fail  = 0;

    job_t            exp_launch[$];
    job_t            pipe_q[$];
    int              pipe_due[$];
    logic [RW-1:0]   exp_rsp[$];
    int              grant_log[$];
    int              launch_cyc[$];

    int   cyc = 0, m_inflight = 0, m_outbuf = 0, m_rr = NREQ - 1;
    int   xfer_total = 0, rsp_total = 0;
    bit   m_err = 1'b0, m_pen = 1'b0, hold_prev = 1'b0;
    logic [RW-1:0] hold_val;

    bit auto_done = 1'b1;
    int man_req = 0, man_cnt = 0, spur_req = 0, spur_cnt = 0;

    task automatic chk(input string nm, input logic [271:0] act, input logic [271:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Stand-in pipeline digest: any deterministic function of (len, data) suffices here.
    function automatic logic [HASH_W-1:0] ref_digest(input logic [LEN_W-1:0] len,
                                                     input logic [DATA_W-1:0] data);
        logic [HASH_W-1:0] h;
        h = {(HASH_W/32){32'h9e3779b9}};
        for (int i = 0; i < int'(DATA_W); i++)
            if (data[i]) h[8'((i * 37 + int'(len)) % 256)] ^= 1'b1;
        h[LEN_W-1:0] ^= len;
        return h;
    endfunction

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        for (int w = 0; w < int'(DATA_W / 32); w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    // Monitor / scoreboard: compare registered state first, then apply this cycle's events.
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_rdy;
        cyc++;
        if (rst) begin
            m_inflight = 0; m_outbuf = 0; m_rr = NREQ - 1; m_err = 1'b0; m_pen = 1'b0;
            hold_prev = 1'b0;
            exp_launch.delete(); pipe_q.delete(); pipe_due.delete(); exp_rsp.delete();
            chk("rst_outputs", 272'({req_ready, pipe_en, pipe_len, rsp_valid, rsp_id, err}), 272'(0));
            chk("rst_data", 272'({pipe_data != '0, rsp_hash != '0}), 272'(0));
        end else begin
            chk("err", 272'(err), 272'(m_err));
            chk("rsp_valid", 272'(rsp_valid), 272'(m_outbuf != 0));
            chk("pipe_en", 272'(pipe_en), 272'(m_pen));
            exp_rdy = '0;
            if (int'(CRED) - m_inflight - m_outbuf > 0)
                for (int k = 1; k <= int'(NREQ); k++)
                    if (exp_rdy == '0 && req_valid[(m_rr + k) % NREQ]) exp_rdy[(m_rr + k) % NREQ] = 1'b1;
            chk("req_ready", 272'(req_ready), 272'(exp_rdy));
            if (hold_prev) chk("rsp_hold", 272'({rsp_valid, rsp_id, rsp_hash}), 272'({1'b1, hold_val}));

            m_pen = 1'b0;
            if (pipe_en) begin
                launch_cyc.push_back(cyc);
                if (exp_launch.size() > 0) begin
                    job_t j;
                    j = exp_launch.pop_front();
                    chk("pipe_len", 272'(pipe_len), 272'(j.len));
                    for (int c = 0; c < 8; c++)
                        chk("pipe_data", 272'(pipe_data[c*136 +: 136]), 272'(j.data[c*136 +: 136]));
                    pipe_q.push_back(j);
                    pipe_due.push_back(cyc + int'($urandom_range(1, 6)));
                end
            end
            if (pipe_done) begin
                if (m_inflight == 0) m_err = 1'b1;
                else begin m_inflight--; m_outbuf++; end
            end
            if (rsp_valid && rsp_ready) begin
                rsp_total++;
                if (exp_rsp.size() == 0) chk("rsp_unexpected", 272'(1), 272'(0));
                else chk("rsp", 272'({rsp_id, rsp_hash}), 272'(exp_rsp.pop_front()));
                if (m_outbuf > 0) m_outbuf--;
            end
            for (int i = 0; i < int'(NREQ); i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    job_t j;
                    j.id = i;
                    j.len = req_len[i*LEN_W +: LEN_W];
                    j.data = req_data[i*DATA_W +: DATA_W];
                    exp_launch.push_back(j);
                    exp_rsp.push_back({IDW'(i), ref_digest(j.len, j.data)});
                    grant_log.push_back(i);
                    m_inflight++; m_rr = i; m_pen = 1'b1; xfer_total++;
                end
            end
            hold_prev = rsp_valid && !rsp_ready;
            hold_val  = {rsp_id, rsp_hash};
        end
    end

    // In-order pipeline model: completes jobs after a random latency, or on manual request.
    initial begin
        pipe_done = 1'b0;
        pipe_hash = '0;
        forever begin
            @(posedge clk);
            #2;
            pipe_done = 1'b0;
            pipe_hash = '0;
            if (spur_cnt < spur_req) begin
                spur_cnt++;
                pipe_done = 1'b1;
                pipe_hash = {8{$urandom}};
            end else if (pipe_q.size() > 0 &&
                         ((auto_done && cyc >= pipe_due[0]) || (!auto_done && man_cnt < man_req))) begin
                job_t j;
                if (!auto_done) man_cnt++;
                j = pipe_q.pop_front();
                void'(pipe_due.pop_front());
                pipe_done = 1'b1;
                pipe_hash = ref_digest(j.len, j.data);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < int'(NREQ); i++) begin
            req_len[i*LEN_W +: LEN_W]    = LEN_W'($urandom_range(0, 136));
            req_data[i*DATA_W +: DATA_W] = rand_data();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; auto_done = 1'b1;
        step(3);
        rst = 1'b0;
        step(1);
        chk("post_reset_credit", 272'(dut.credit), 272'(CRED));
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((m_inflight != 0 || m_outbuf != 0) && n < 300) begin step(1); n++; end
        chk(nm, 272'(m_inflight + m_outbuf), 272'(0));
        chk({nm, "_sb_empty"}, 272'(exp_rsp.size()), 272'(0));
    endtask

    initial begin
        int x0, g0, l0, r0, n;
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_len = '0; req_data = '0;
        step(3);
        chk("reset_credit", 272'(dut.credit), 272'(CRED));
        chk("reset_ready", 272'(req_ready), 272'(0));
        rst = 1'b0;
        step(1);

        // Single request from requester 2
        rsp_ready = 1'b1;
        req_len[2*LEN_W +: LEN_W] = 11'd3;
        req_data[2*DATA_W +: DATA_W] = DATA_W'(24'h616263);
        x0 = xfer_total; r0 = rsp_total;
        req_valid = 4'b0100;
        step(1);
        req_valid = '0;
        chk("single_xfer", 272'(xfer_total - x0), 272'(1));
        chk("single_grant", 272'(grant_log[grant_log.size()-1]), 272'(2));
        n = 0;
        while (rsp_total == r0 && n < 50) begin step(1); n++; end
        chk("single_rsp", 272'(rsp_total - r0), 272'(1));
        wait_idle("single_drain");

        // Fairness with all requesters valid
        do_reset();
        rsp_ready = 1'b1;
        fill_random();
        g0 = grant_log.size(); l0 = launch_cyc.size();
        req_valid = 4'hF;
        step(8);
        req_valid = '0;
        step(2);
        if (grant_log.size() >= g0 + 8) begin
            for (int k = 0; k < 8; k++) chk("fair_order", 272'(grant_log[g0+k]), 272'(k % 4));
        end else chk("fair_grants", 272'(grant_log.size() - g0), 272'(8));
        chk("fair_launches", 272'(launch_cyc.size() - l0), 272'(8));
        if (launch_cyc.size() >= l0 + 8)
            chk("fair_back_to_back", 272'(launch_cyc[l0+7] - launch_cyc[l0]), 272'(7));
        wait_idle("fair_drain");

        // Credit stall with responses held
        do_reset();
        x0 = xfer_total;
        req_valid = 4'hF;
        for (int k = 0; k < 30; k++) begin fill_random(); step(1); end
        chk("stall_count", 272'(xfer_total - x0), 272'(CRED));
        chk("stall_ready", 272'(req_ready), 272'(0));
        rsp_ready = 1'b1;
        step(1);
        rsp_ready = 1'b0;
        step(6);
        chk("stall_one_more", 272'(xfer_total - x0), 272'(CRED + 1));
        req_valid = '0; rsp_ready = 1'b1;
        wait_idle("stall_drain");

        // Transfer, done and pop on one edge with 5 in flight
        do_reset();
        auto_done = 1'b0;
        fill_random();
        req_valid = 4'h1;
        step(6);
        req_valid = '0;
        step(3);
        man_req++;
        step(3);
        chk("sim_pre_inflight", 272'(dut.id_count), 272'(5));
        chk("sim_pre_outbuf", 272'(dut.out_count), 272'(1));
        x0 = xfer_total; r0 = rsp_total;
        req_valid = 4'h2; rsp_ready = 1'b1; man_req++;
        step(1);
        req_valid = '0; rsp_ready = 1'b0;
        chk("sim_inflight", 272'(dut.id_count), 272'(5));
        chk("sim_outbuf", 272'(dut.out_count), 272'(1));
        chk("sim_events", 272'({xfer_total - x0, rsp_total - r0}), 272'({32'd1, 32'd1}));
        auto_done = 1'b1; rsp_ready = 1'b1;
        wait_idle("sim_drain");

        // Spurious done with nothing in flight
        do_reset();
        spur_req++;
        step(4);
        chk("spur_err", 272'(err), 272'(1));
        chk("spur_no_rsp", 272'(rsp_valid), 272'(0));
        step(5);
        chk("spur_err_held", 272'(err), 272'(1));
        do_reset();
        chk("spur_err_cleared", 272'(err), 272'(0));

        // Asynchronous reset with 6 jobs in flight
        do_reset();
        auto_done = 1'b0;
        fill_random();
        req_valid = 4'hF;
        step(6);
        chk("mid_inflight", 272'(dut.id_count), 272'(6));
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ctrl", 272'({req_ready, pipe_en, rsp_valid, rsp_id, err}), 272'(0));
        chk("mid_rst_len", 272'(pipe_len), 272'(0));
        chk("mid_rst_data", 272'(pipe_data != '0), 272'(0));
        chk("mid_rst_hash", 272'(rsp_hash), 272'(0));
        chk("mid_rst_credit", 272'(dut.credit), 272'(CRED));
        req_valid = '0;
        step(2);
        rst = 1'b0; auto_done = 1'b1;
        step(1);
        chk("mid_credit_after", 272'(dut.credit), 272'(CRED));

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            fill_random();
            req_valid = NREQ'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            step(1);
        end
        req_valid = '0; rsp_ready = 1'b1;
        wait_idle("random_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit (%0d tests, %0d failed)", n_tests, n_fail);
        $fatal(1);
    end

endmodule

// File: doc/shake256_sched.md
SHAKE256_SCHED -- requirements
Module: shake256_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters, 2..8.
REQ-002 SHALL have parameter IDW, default 2: requester-id width, equal to ceil(log2(NREQ)).
REQ-003 SHALL have parameter CRED, default 16: output-buffer depth, power of two, 4..32.
REQ-004 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid, input, NREQ: per-requester message valid.
REQ-007 SHALL have port req_ready, output, NREQ: per-requester accept; a transfer occurs when valid and ready are both high.
REQ-008 SHALL have port req_len, input, NREQ*11: message byte length per requester, slice i at [11*i +: 11].
REQ-009 SHALL have port req_data, input, NREQ*1088: unpadded message block per requester, slice i at [1088*i +: 1088].
REQ-010 SHALL have port pipe_en, output, 1: one-cycle launch strobe to the SHAKE256 pipeline.
REQ-011 SHALL have port pipe_len, output, 11: launched length.
REQ-012 SHALL have port pipe_data, output, 1088: launched block.
REQ-013 SHALL have port pipe_done, input, 1: pipeline result strobe.
REQ-014 SHALL have port pipe_hash, input, 256: result, valid with pipe_done.
REQ-015 SHALL have port rsp_valid, output, 1: response valid.
REQ-016 SHALL have port rsp_ready, input, 1: response accept.
REQ-017 SHALL have port rsp_id, output, IDW: id of the requester that owns the response.
REQ-018 SHALL have port rsp_hash, output, 256: digest.
REQ-019 SHALL have port err, output, 1: sticky protocol error.

Function
REQ-020 SHALL grant at most one requester per cycle, chosen by round-robin starting from the index after the last granted one; req_ready SHALL be one-hot or zero.
REQ-021 SHALL assert req_ready[i] only when req_valid[i] is high, requester i wins arbitration, and credit is greater than 0.
REQ-022 SHALL keep credit = CRED - inflight - outbuf_count, and SHALL never launch when credit is 0.
REQ-023 SHALL register the accepted len/data and drive pipe_en high for exactly one cycle, the cycle after the transfer, with pipe_len/pipe_data stable during that cycle; this gives one launch per cycle at most and back-to-back launches are allowed.
REQ-024 SHALL push the granted id into an in-order id FIFO on transfer.
REQ-025 SHALL pop the id FIFO on each pipe_done and write {id, pipe_hash} into the output buffer in the same edge; the pipeline is in-order and has no backpressure.
REQ-026 SHALL present the output-buffer head on rsp_*; rsp_valid SHALL rise the cycle after the pipe_done cycle when the buffer was empty; hold rsp_* stable while rsp_valid is high and rsp_ready is low.
REQ-027 SHALL handle a pop (rsp_valid and rsp_ready) and a pipe_done on the same edge with occupancy unchanged and no data loss.
REQ-028 SHALL handle a transfer and a pipe_done on the same edge: inflight unchanged, credit updated by the net change only.
REQ-029 SHALL drop pipe_done while the id FIFO is empty (no write) and set err; err SHALL clear only on reset.
REQ-030 SHALL let pointers wrap modulo CRED; the full condition SHALL be distinguished by an extra pointer bit.

Reset
REQ-031 SHALL, while rst is high, force req_ready=0, pipe_en=0, pipe_len=0, pipe_data=0, rsp_valid=0, rsp_id=0, rsp_hash=0, err=0, round-robin pointer=NREQ-1, FIFOs empty, credit=CRED.
REQ-032 SHALL discard in-flight jobs on reset mid-operation; pipe_done strobes arriving after reset deassertion with the id FIFO empty SHALL set err, and the integrator resets the pipeline together with this block.

Structure
REQ-033 SHALL take the constants DATA_W=1088, LEN_W=11 and HASH_W=256 from shared package shake_pkg.
REQ-034 SHALL implement both the id FIFO and the output buffer with one parameterised sub-module, sync_fifo (width, depth, count output).

Verification
REQ-035 SHALL cover a single request: requester 2, len=3, data=0x616263 -> pipe_en one cycle after transfer; on pipe_done rsp_id=2 and rsp_hash equal to the model digest, rsp_valid one cycle later.
REQ-036 SHALL cover fairness: all four valid continuously -> grant order 0,1,2,3,0,1,...; 8 launches on 8 consecutive cycles.
REQ-037 SHALL cover credit stall: rsp_ready=0 with CRED=16 -> exactly 16 transfers, then req_ready stays 0; one rsp pop -> exactly one further transfer.
REQ-038 SHALL cover simultaneous events: transfer, pipe_done and rsp pop on one edge with 5 in flight -> inflight stays 5, no lost or duplicated response.
REQ-039 SHALL cover a spurious done: pipe_done with nothing in flight -> err=1, rsp_valid stays 0, err held until rst.
REQ-040 SHALL cover reset mid-stream: rst asserted with 6 in flight -> all outputs at reset values immediately (asynchronously), credit=16 after release.
